// File: rtl/shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// shift_reg_pkg
// Shared definitions for the burst shift register: command op codes and the
// two-state controller encoding.
// ---------------------------------------------------------------------------
package shift_reg_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHR   = 3'b010;
    localparam logic [2:0] OP_SHL   = 3'b011;
    localparam logic [2:0] OP_ASR   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ROL   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Ops that take a distance and may become multi-cycle bursts.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ASR) ||
               (op == OP_ROR) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Combinational single-position shift/rotate.
// Ports:
//   q_i         current register value
//   op_i        operation (SHR/SHL/ASR/ROR/ROL; anything else passes q_i)
//   serial_in_i fill bit for SHR (into MSB) and SHL (into LSB)
//   q_next_o    value after one step
// ---------------------------------------------------------------------------
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       op_i,
    input  logic             serial_in_i,
    output logic [WIDTH-1:0] q_next_o
);

    always_comb begin
        q_next_o = q_i;
        case (op_i)
            OP_SHR:  q_next_o = {serial_in_i, q_i[WIDTH-1:1]};
            OP_SHL:  q_next_o = {q_i[WIDTH-2:0], serial_in_i};
            OP_ASR:  q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            OP_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
            OP_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            default: q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/shift_reg_burst.sv
// ---------------------------------------------------------------------------
// shift_reg_burst
// Universal shift register taking one command per valid/ready handshake.
// Single-cycle ops (NOP, LOAD, CLEAR, zero-distance shifts) complete on the
// accept edge; shifts with a nonzero distance run one position per clock.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a command; single-cycle ops execute here
//   ST_RUN  | burst in progress, one step per edge until count reaches 0
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   cmd_valid/ready    command handshake (ready only in IDLE)
//   cmd_op/cnt/par_in  operation, shift distance, parallel load data
//   serial_in          fill bit for SHR/SHL, sampled on each shift edge
//   abort              stops a running burst without a done pulse
//   q, serial_out      register contents, bit leaving on next shift
//   busy, done         burst running, one-cycle completion pulse
// ---------------------------------------------------------------------------
module shift_reg_burst
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] par_in,
    input  logic             serial_in,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] step_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] eff_cnt_d;
    logic [2:0]       op_q;
    logic             done_q;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q_i         (q_q),
        .op_i        (op_q),
        .serial_in_i (serial_in),
        .q_next_o    (step_d)
    );

    // Distances beyond the register width are clamped, rotates included.
    assign eff_cnt_d = (cmd_cnt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (is_shift_op(cmd_op) && (eff_cnt_d != '0)) begin
                            op_q    <= cmd_op;
                            cnt_q   <= eff_cnt_d;
                            state_q <= ST_RUN;
                        end else begin
                            if (cmd_op == OP_LOAD) q_q <= par_in;
                            else if (cmd_op == OP_CLEAR) q_q <= '0;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        q_q   <= step_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign q         = q_q;
    assign done      = done_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);

    // Left-moving ops shed the MSB; everything else (and IDLE) shows the LSB.
    always_comb begin
        serial_out = q_q[0];
        if ((state_q == ST_RUN) && ((op_q == OP_SHL) || (op_q == OP_ROL)))
            serial_out = q_q[WIDTH-1];
    end

endmodule

// File: tb/tb_shift_reg_burst.sv
module tb_shift_reg_burst;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_cnt = 4'd0;
    logic [7:0] par_in = 8'd0;
    logic       serial_in = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] q;
    logic       serial_out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail = 0;
    int mq = 0;

    shift_reg_burst #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .par_in(par_in),
        .serial_in(serial_in), .abort(abort), .q(q), .serial_out(serial_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // done and busy must never overlap
    always @(negedge clk) begin
        if (rst) begin
            n_checks++;
            if (done && busy) begin
                n_fail++;
                $display("FAIL done_busy_overlap done=%b busy=%b", done, busy);
            end
        end
    end

    // Reference: one step expressed as integer arithmetic on an 8-bit value.
    function automatic int model_step(input int op, input int v, input int sin);
        case (op)
            2: return (v >> 1) | (sin << 7);
            3: return ((v << 1) & 255) | sin;
            4: return (v >> 1) | (v & 128);
            5: return (v >> 1) | ((v & 1) << 7);
            6: return ((v << 1) & 255) | (v >> 7);
            default: return v;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_cnt = cnt;
        par_in = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks += 4;
        if (q !== 8'h00) begin n_fail++; $display("FAIL rst_q got=%h exp=00", q); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", done); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        serial_in = 1'b1;
        send(3'd1, 4'd0, 8'hA5);
        send(3'd2, 4'd5, 8'h00);
        tick();
        n_checks++;
        if (q !== 8'hD2) begin n_fail++; $display("FAIL rst_pre_q got=%h exp=d2", q); end
        #2 rst = 1'b0;
        #1;
        n_checks += 4;
        if (q !== 8'h00) begin n_fail++; $display("FAIL rst_mid_q got=%h exp=00", q); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got=%b exp=1", cmd_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got=%b exp=0", done); end
        #2 rst = 1'b1;
        tick();
        tick();
        n_checks += 2;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_after_done got=%b exp=0", done); end
        if (q !== 8'h00) begin n_fail++; $display("FAIL rst_after_q got=%h exp=00", q); end
        mq = 0;
    endtask

    task automatic test_shr();
        send(3'd1, 4'd0, 8'hA5);
        mq = 8'hA5;
        n_checks += 2;
        if (q !== 8'hA5) begin n_fail++; $display("FAIL load_q got=%h exp=a5", q); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL load_done got=%b exp=1", done); end
        serial_in = 1'b1;
        send(3'd2, 4'd3, 8'h00);
        n_checks += 2;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL shr_busy got=%b exp=1", busy); end
        if (q !== 8'hA5) begin n_fail++; $display("FAIL shr_accept_q got=%h exp=a5", q); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (serial_out !== 1'(mq & 1)) begin n_fail++; $display("FAIL shr_sout%0d got=%b exp=%b", i, serial_out, mq & 1); end
            tick();
            mq = model_step(2, mq, 1);
            n_checks++;
            if (q !== 8'(mq)) begin n_fail++; $display("FAIL shr_q%0d got=%h exp=%h", i, q, 8'(mq)); end
            if (i < 2) begin
                n_checks++;
                if (done !== 1'b0) begin n_fail++; $display("FAIL shr_early_done got=%b exp=0", done); end
            end
        end
        n_checks += 4;
        if (q !== 8'hF4) begin n_fail++; $display("FAIL shr_final got=%h exp=f4", q); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL shr_done got=%b exp=1", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL shr_end_busy got=%b exp=0", busy); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL shr_end_ready got=%b exp=1", cmd_ready); end
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL shr_done_width got=%b exp=0", done); end
    endtask

    task automatic test_asr_rol();
        int cycles;
        send(3'd1, 4'd0, 8'h80);
        send(3'd4, 4'd7, 8'h00);
        cycles = 0;
        while (busy && cycles < 20) begin tick(); cycles++; end
        n_checks += 3;
        if (cycles != 7) begin n_fail++; $display("FAIL asr_cycles got=%0d exp=7", cycles); end
        if (q !== 8'hFF) begin n_fail++; $display("FAIL asr_q got=%h exp=ff", q); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL asr_done got=%b exp=1", done); end
        send(3'd1, 4'd0, 8'h81);
        send(3'd6, 4'd9, 8'h00);
        cycles = 0;
        while (busy && cycles < 20) begin tick(); cycles++; end
        n_checks += 3;
        if (cycles != 8) begin n_fail++; $display("FAIL rol_cycles got=%0d exp=8", cycles); end
        if (q !== 8'h81) begin n_fail++; $display("FAIL rol_q got=%h exp=81", q); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL rol_done got=%b exp=1", done); end
    endtask

    task automatic test_abort();
        serial_in = 1'b0;
        send(3'd1, 4'd0, 8'h01);
        send(3'd3, 4'd5, 8'h00);
        n_checks++;
        if (serial_out !== 1'b0) begin n_fail++; $display("FAIL shl_sout got=%b exp=0", serial_out); end
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks += 4;
        if (q !== 8'h04) begin n_fail++; $display("FAIL abort_q got=%h exp=04", q); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got=%b exp=1", cmd_ready); end
        tick();
        n_checks += 2;
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort_late_done got=%b exp=0", done); end
        if (q !== 8'h04) begin n_fail++; $display("FAIL abort_hold_q got=%h exp=04", q); end
        abort = 1'b1;
        send(3'd1, 4'd0, 8'h3C);
        abort = 1'b0;
        mq = 8'h3C;
        n_checks += 2;
        if (q !== 8'h3C) begin n_fail++; $display("FAIL idle_abort_q got=%h exp=3c", q); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL idle_abort_done got=%b exp=1", done); end
    endtask

    task automatic test_cnt0_ignore();
        send(3'd2, 4'd0, 8'h00);
        n_checks += 3;
        if (q !== 8'h3C) begin n_fail++; $display("FAIL cnt0_q got=%h exp=3c", q); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL cnt0_done got=%b exp=1", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL cnt0_busy got=%b exp=0", busy); end
        send(3'd1, 4'd0, 8'h5A);
        mq = 8'h5A;
        cmd_valid = 1'b1;
        cmd_op = 3'd5;
        cmd_cnt = 4'd4;
        tick();
        cmd_op = 3'd1;
        par_in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) cmd_valid = 1'b0;
            tick();
            mq = model_step(5, mq, 0);
            n_checks++;
            if (q !== 8'(mq)) begin n_fail++; $display("FAIL ignore_q%0d got=%h exp=%h", i, q, 8'(mq)); end
        end
        n_checks += 2;
        if (q !== 8'hA5) begin n_fail++; $display("FAIL ror4_q got=%h exp=a5", q); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL ror4_done got=%b exp=1", done); end
        tick();
        n_checks++;
        if (q !== 8'hA5) begin n_fail++; $display("FAIL ignore_after_q got=%h exp=a5", q); end
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1;
        cmd_op = 3'd1;
        par_in = 8'h11;
        tick();
        n_checks += 3;
        if (q !== 8'h11) begin n_fail++; $display("FAIL b2b_q1 got=%h exp=11", q); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1 got=%b exp=1", done); end
        if (serial_out !== 1'b1) begin n_fail++; $display("FAIL b2b_sout got=%b exp=1", serial_out); end
        par_in = 8'h22;
        tick();
        n_checks += 2;
        if (q !== 8'h22) begin n_fail++; $display("FAIL b2b_q2 got=%h exp=22", q); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2 got=%b exp=1", done); end
        cmd_op = 3'd7;
        tick();
        cmd_valid = 1'b0;
        n_checks += 2;
        if (q !== 8'h00) begin n_fail++; $display("FAIL b2b_q3 got=%h exp=00", q); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done3 got=%b exp=1", done); end
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_end got=%b exp=0", done); end
        mq = 0;
    endtask

    task automatic test_random();
        int op, cnt, eff, d, sin, abort_at;
        bit aborted;
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 7));
            cnt = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 255));
            eff = (cnt > 8) ? 8 : cnt;
            send(3'(op), 4'(cnt), 8'(d));
            if (op >= 2 && op <= 6 && eff > 0) begin
                abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, eff - 1)) : -1;
                aborted = 1'b0;
                n_checks++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL rnd_busy it=%0d got=%b exp=1", it, busy); end
                for (int s = 0; s < eff && !aborted; s++) begin
                    sin = int'($urandom_range(0, 1));
                    serial_in = 1'(sin);
                    n_checks++;
                    if (serial_out !== ((op == 3 || op == 6) ? 1'((mq >> 7) & 1) : 1'(mq & 1))) begin
                        n_fail++; $display("FAIL rnd_sout it=%0d step=%0d got=%b", it, s, serial_out);
                    end
                    if (s == abort_at) begin
                        abort = 1'b1;
                        tick();
                        abort = 1'b0;
                        aborted = 1'b1;
                    end else begin
                        tick();
                        mq = model_step(op, mq, sin);
                    end
                    n_checks++;
                    if (q !== 8'(mq)) begin n_fail++; $display("FAIL rnd_q it=%0d step=%0d got=%h exp=%h", it, s, q, 8'(mq)); end
                end
                n_checks += 2;
                if (done !== !aborted) begin n_fail++; $display("FAIL rnd_done it=%0d got=%b exp=%b", it, done, !aborted); end
                if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_end_busy it=%0d got=%b exp=0", it, busy); end
            end else begin
                if (op == 1) mq = d;
                else if (op == 7) mq = 0;
                n_checks += 3;
                if (q !== 8'(mq)) begin n_fail++; $display("FAIL rnd_single_q it=%0d got=%h exp=%h", it, q, 8'(mq)); end
                if (done !== 1'b1) begin n_fail++; $display("FAIL rnd_single_done it=%0d got=%b exp=1", it, done); end
                if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_single_busy it=%0d got=%b exp=0", it, busy); end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_shr();
        test_asr_rol();
        test_abort();
        test_cnt0_ignore();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
